bundler: RTL and testbench
==========================

BUNDLER -- requirements
Module: bundler

Interface
REQ-001 Parameter DIMENSIONS, default 10000, hypervector width in bits (>=1).
REQ-002 Parameter NUM_HVS, default 5, number of input hypervectors bundled (>=1).
REQ-003 Parameter PAR_BITS, default 100, dimensions evaluated per clock cycle (1..DIMENSIONS).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 en  input  1  start strobe; sampled on rising edge.
REQ-007 hv_array  input  [NUM_HVS-1:0][DIMENSIONS-1:0]  packed array of input hypervectors.
REQ-008 out  output  1  done pulse, high exactly one cycle when hv_out holds a new result.
REQ-009 hv_out  output  DIMENSIONS  bundled (bitwise majority) result, registered.

Function
REQ-010 Result bit d SHALL be 1 iff count of hv_array[i][d]==1 over i is greater than NUM_HVS/2 (strict majority).
REQ-011 Even NUM_HVS tie (count == NUM_HVS/2) SHALL resolve to 0.
REQ-012 States: IDLE, BUSY. In IDLE, en=1 at an edge SHALL capture hv_array into an internal register and enter BUSY; capture edge is cycle 0.
REQ-013 BUSY SHALL process chunk c (bits c*PAR_BITS upward) on edge c+1, for NCHUNK = ceil(DIMENSIONS/PAR_BITS) chunks; final chunk may be partial, upper unused positions ignored.
REQ-014 Chunk results SHALL accumulate in an internal result register; hv_out SHALL update all DIMENSIONS bits at once on edge NCHUNK, together with out=1 and return to IDLE.
REQ-015 out SHALL be 1 only for the cycle following edge NCHUNK, else 0; latency en-edge to out-high = NCHUNK edges (3 for DIMENSIONS=6, PAR_BITS=2).
REQ-016 hv_out SHALL hold its value between results; never shows partial results.
REQ-017 en while BUSY SHALL be ignored; hv_array changes after the capture edge SHALL not affect the result.
REQ-018 en sampled at the same edge out is asserted (back in IDLE) SHALL start a new operation.
REQ-019 Per-bit count width SHALL be $clog2(NUM_HVS+1); no overflow possible.

Reset
REQ-020 rst=1 at an edge SHALL force IDLE, out=0, hv_out=0, chunk counter=0, captured/accumulator registers=0; rst has priority over en.
REQ-021 rst during BUSY SHALL abort the operation with no out pulse.

Structure
REQ-022 Shared package bundler_pkg SHALL hold the state enum (IDLE, BUSY) and helper functions for NCHUNK and count width.
REQ-023 One sub-module majority_vote (parameter NUM_HVS; NUM_HVS-bit input column, 1-bit majority output, combinational) SHALL be instantiated PAR_BITS times.

Verification
REQ-024 D=6,N=5,P=2: rst, then en one cycle with {001101,000111,001111,100011,100011} (hv_array[0..4]) -> out pulse 3 edges later, hv_out=000111.
REQ-025 Same config: {000010,010000,001000,010100,000100} -> hv_out=000000, out single-cycle.
REQ-026 Same config: {111011,011011,001111,010111,110101} -> hv_out=011111; hv_out held unchanged until next out.
REQ-027 en held high / toggled and hv_array changed during BUSY -> result equals first captured set, one out pulse per accepted start.
REQ-028 rst asserted mid-BUSY -> no out pulse, hv_out=0; N=4 tie column (two ones) -> result bit 0.
REQ-029 D=7,P=3 (partial last chunk) random vectors -> out after 3 edges, hv_out matches bitwise majority model.

Source files
------------

// File: rtl/bundler_pkg.sv
// Shared definitions for the bundler block.
// Purpose : FSM state type plus elaboration-time helpers used to size
//           the chunk counter, the per-column ones counter and bit indices.
// Ports   : none (package)
package bundler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Number of PAR_BITS-wide slices needed to cover a hypervector,
  // rounding up so a partial final slice still gets its own cycle.
  function automatic int nChunks(input int dims, input int parBits);
    return (dims + parBits - 1) / parBits;
  endfunction

  // Width able to hold any value 0..n (ones count of an n-bit column,
  // or a chunk counter reaching n).
  function automatic int countWidth(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index selecting one of dims bits; never below one bit.
  function automatic int indexWidth(input int dims);
    return (dims > 1) ? $clog2(dims) : 1;
  endfunction

endpackage

// File: rtl/bundler_majority_vote.sv
// Combinational strict-majority voter for one hypervector column.
// Purpose : majority_o is 1 when more than half of the NUM_HVS input bits
//           are 1; an exact tie on an even NUM_HVS resolves to 0.
// Ports   : column_i   [NUM_HVS-1:0]  one bit from each input hypervector
//           majority_o                 voted result bit
module majority_vote
  import bundler_pkg::*;
#(
  parameter int NUM_HVS = 5
) (
  input  logic [NUM_HVS-1:0] column_i,
  output logic               majority_o
);

  localparam int CW = countWidth(NUM_HVS);
  localparam logic [CW-1:0] HALF = CW'(NUM_HVS / 2);

  logic [CW-1:0] onesCount;

  // Population count of the column; CW is wide enough that it cannot wrap.
  always_comb begin
    onesCount = '0;
    for (int i = 0; i < NUM_HVS; i++) begin
      onesCount = onesCount + CW'(column_i[i]);
    end
  end

  // Strict greater-than makes an even split vote 0.
  assign majority_o = (onesCount > HALF);

endmodule

// File: rtl/bundler.sv
// Hypervector bundler (bitwise majority over NUM_HVS hypervectors).
// Purpose : on an en strobe in IDLE the input set is captured, then
//           PAR_BITS columns are voted per cycle into an accumulator. When
//           the last chunk is done the full result is published on hv_out
//           in one step and out pulses for one cycle.
// Ports   : clk       clock, rising edge
//           rst       synchronous active-high reset
//           en        start strobe (ignored while busy)
//           hv_array  [NUM_HVS-1:0][DIMENSIONS-1:0] input hypervectors
//           out       one-cycle done pulse
//           hv_out    [DIMENSIONS-1:0] registered bundled result
module bundler
  import bundler_pkg::*;
#(
  parameter int DIMENSIONS = 10000,
  parameter int NUM_HVS    = 5,
  parameter int PAR_BITS   = 100
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [NUM_HVS-1:0][DIMENSIONS-1:0]  hv_array,
  output logic                                out,
  output logic [DIMENSIONS-1:0]               hv_out
);

  localparam int NCHUNK = nChunks(DIMENSIONS, PAR_BITS);
  localparam int CHW    = countWidth(NCHUNK);
  localparam int IW     = indexWidth(DIMENSIONS);
  localparam logic [CHW-1:0] LAST_CHUNK = CHW'(NCHUNK - 1);

  state_e                              stateQ;
  logic [CHW-1:0]                      chunkQ;
  logic [NUM_HVS-1:0][DIMENSIONS-1:0]  capQ;
  logic [DIMENSIONS-1:0]               accQ;
  logic [DIMENSIONS-1:0]               accD;
  logic [DIMENSIONS-1:0]               hvOutQ;
  logic                                outQ;

  logic [PAR_BITS-1:0][NUM_HVS-1:0]    columns;
  logic [PAR_BITS-1:0]                 votes;
  logic [PAR_BITS-1:0]                 laneValid;
  logic [PAR_BITS-1:0][IW-1:0]         laneIdx;

  // Map each voting lane to its absolute bit position in the current
  // chunk; lanes past the top of a partial final chunk are disabled.
  always_comb begin
    laneValid = '0;
    laneIdx   = '0;
    for (int p = 0; p < PAR_BITS; p++) begin
      if (int'(chunkQ) * PAR_BITS + p < DIMENSIONS) begin
        laneValid[p] = 1'b1;
        laneIdx[p]   = IW'(int'(chunkQ) * PAR_BITS + p);
      end
    end
  end

  // Gather one column per lane from the captured set.
  always_comb begin
    columns = '0;
    for (int p = 0; p < PAR_BITS; p++) begin
      for (int i = 0; i < NUM_HVS; i++) begin
        if (laneValid[p]) begin
          columns[p][i] = capQ[i][laneIdx[p]];
        end
      end
    end
  end

  for (genvar g = 0; g < PAR_BITS; g++) begin : gVote
    majority_vote #(
      .NUM_HVS(NUM_HVS)
    ) uVote (
      .column_i  (columns[g]),
      .majority_o(votes[g])
    );
  end

  // Accumulator with the current chunk's votes merged in; on the last
  // chunk this is the complete result that goes straight to hv_out.
  always_comb begin
    accD = accQ;
    for (int p = 0; p < PAR_BITS; p++) begin
      if (laneValid[p]) begin
        accD[laneIdx[p]] = votes[p];
      end
    end
  end

  // Control FSM. out defaults low every cycle so it can only ever be a
  // single-cycle pulse; hv_out is touched only when a result completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      chunkQ <= '0;
      capQ   <= '0;
      accQ   <= '0;
      hvOutQ <= '0;
      outQ   <= 1'b0;
    end else begin
      outQ <= 1'b0;
      case (stateQ)
        IDLE: begin
          if (en) begin
            capQ   <= hv_array;
            accQ   <= '0;
            chunkQ <= '0;
            stateQ <= BUSY;
          end
        end
        BUSY: begin
          accQ <= accD;
          if (chunkQ == LAST_CHUNK) begin
            hvOutQ <= accD;
            outQ   <= 1'b1;
            chunkQ <= '0;
            stateQ <= IDLE;
          end else begin
            chunkQ <= chunkQ + 1'b1;
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign out    = outQ;
  assign hv_out = hvOutQ;

endmodule

// File: tb/tb_bundler.sv
// Self-checking bench for bundler.
// Three instances share one clock and reset:
//   A : DIMENSIONS=6, NUM_HVS=5, PAR_BITS=2
//   B : DIMENSIONS=6, NUM_HVS=4, PAR_BITS=2 (even count, ties)
//   C : DIMENSIONS=7, NUM_HVS=5, PAR_BITS=3 (partial last chunk)
// Expected results come from fixed vectors or from refMajority, which
// counts ones per bit position with plain arithmetic.
module tb_bundler;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;

  logic            enA, enB, enC;
  logic [4:0][5:0] hvA;
  logic [3:0][5:0] hvB;
  logic [4:0][6:0] hvC;
  logic            outA, outB, outC;
  logic [5:0]      hvOutA, hvOutB;
  logic [6:0]      hvOutC;

  int assertCount = 0;
  int failCount   = 0;

  bundler #(.DIMENSIONS(6), .NUM_HVS(5), .PAR_BITS(2)) dutA (
    .clk(clk), .rst(rst), .en(enA), .hv_array(hvA), .out(outA), .hv_out(hvOutA)
  );

  bundler #(.DIMENSIONS(6), .NUM_HVS(4), .PAR_BITS(2)) dutB (
    .clk(clk), .rst(rst), .en(enB), .hv_array(hvB), .out(outB), .hv_out(hvOutB)
  );

  bundler #(.DIMENSIONS(7), .NUM_HVS(5), .PAR_BITS(3)) dutC (
    .clk(clk), .rst(rst), .en(enC), .hv_array(hvC), .out(outC), .hv_out(hvOutC)
  );

  // Free-running clock, 10 time units per period.
  initial forever #5 clk = ~clk;

  // Compares one observed value against its expectation and tallies it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expVal);
    assertCount++;
    if (got !== expVal) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expVal);
    end
  endtask

  // Bitwise strict majority over the first n vectors, d bits wide.
  function automatic logic [7:0] refMajority(input logic [4:0][7:0] vec, input int n, input int d);
    logic [7:0] res;
    res = '0;
    for (int b = 0; b < d; b++) begin
      int ones;
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(vec[i][b]);
      res[b] = (2 * ones > n);
    end
    return res;
  endfunction

  function automatic logic [4:0][7:0] randVec();
    logic [4:0][7:0] v;
    for (int i = 0; i < 5; i++) v[i] = 8'($urandom);
    return v;
  endfunction

  // Drives en and hv_array of the selected instance.
  task automatic driveInputs(input int which, input logic [4:0][7:0] vec, input logic enVal);
    case (which)
      0: begin
        for (int i = 0; i < 5; i++) hvA[i] = vec[i][5:0];
        enA = enVal;
      end
      1: begin
        for (int i = 0; i < 4; i++) hvB[i] = vec[i][5:0];
        enB = enVal;
      end
      default: begin
        for (int i = 0; i < 5; i++) hvC[i] = vec[i][6:0];
        enC = enVal;
      end
    endcase
  endtask

  task automatic sampleOutputs(input int which, output logic o, output logic [7:0] h);
    case (which)
      0:       begin o = outA; h = {2'b00, hvOutA}; end
      1:       begin o = outB; h = {2'b00, hvOutB}; end
      default: begin o = outC; h = {1'b0, hvOutC}; end
    endcase
  endtask

  // Starts one operation (optionally a second back-to-back one) and
  // watches a fixed window: pulse count, latency, value and hold.
  // With scramble set, en stays high and hv_array is randomised while busy.
  task automatic applyStimulus(input string tag, input int which,
                               input logic [4:0][7:0] vec, input logic [7:0] expVal,
                               input bit scramble, input bit chain,
                               input logic [4:0][7:0] vec2, input logic [7:0] expVal2);
    logic       o;
    logic [7:0] h;
    int         pulses;
    int         firstAt;
    int         secondAt;
    pulses   = 0;
    firstAt  = -1;
    secondAt = -1;
    @(negedge clk);
    driveInputs(which, vec, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      sampleOutputs(which, o, h);
      if (o === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          firstAt = k;
          checkOutput({tag, " result"}, 32'(h), 32'(expVal));
        end else if (pulses == 2) begin
          secondAt = k;
          checkOutput({tag, " second result"}, 32'(h), 32'(expVal2));
        end
      end
      if (chain && k == LAT)         driveInputs(which, vec2, 1'b1);
      else if (scramble && k < LAT)  driveInputs(which, randVec(), 1'b1);
      else                           driveInputs(which, scramble ? randVec() : vec, 1'b0);
    end
    checkOutput({tag, " latency"}, 32'(firstAt), 32'(LAT));
    checkOutput({tag, " pulse count"}, 32'(pulses), chain ? 32'd2 : 32'd1);
    if (chain) checkOutput({tag, " second latency"}, 32'(secondAt), 32'(2 * LAT + 1));
    checkOutput({tag, " hold"}, 32'(h), chain ? 32'(expVal2) : 32'(expVal));
  endtask

  // Starts an operation, resets it mid-flight, and expects no pulse and
  // a cleared result.
  task automatic abortTest(input string tag, input int which, input logic [4:0][7:0] vec);
    logic       o;
    logic [7:0] h;
    int         pulses;
    pulses = 0;
    @(negedge clk);
    driveInputs(which, vec, 1'b1);
    @(negedge clk);
    driveInputs(which, vec, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sampleOutputs(which, o, h);
      if (o === 1'b1) pulses++;
    end
    checkOutput({tag, " pulse count"}, 32'(pulses), 32'd0);
    checkOutput({tag, " cleared result"}, 32'(h), 32'd0);
  endtask

  initial begin
    logic [4:0][7:0] v;
    logic [4:0][7:0] v2;
    logic [4:0][7:0] none;
    logic            o;
    logic [7:0]      h;
    int              pulses;
    none = '0;

    // Reset with en held high on every instance: reset must win.
    rst = 1'b1;
    driveInputs(0, randVec(), 1'b1);
    driveInputs(1, randVec(), 1'b1);
    driveInputs(2, randVec(), 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    driveInputs(0, none, 1'b0);
    driveInputs(1, none, 1'b0);
    driveInputs(2, none, 1'b0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int w = 0; w < 3; w++) begin
        sampleOutputs(w, o, h);
        if (o === 1'b1) pulses++;
        if (k == 0) checkOutput($sformatf("reset hv_out %0d", w), 32'(h), 32'd0);
      end
    end
    checkOutput("reset pulses", 32'(pulses), 32'd0);

    // Directed vectors, listed as hv_array[0..4].
    v = '0;
    v[0] = 8'b001101; v[1] = 8'b000111; v[2] = 8'b001111; v[3] = 8'b100011; v[4] = 8'b100011;
    applyStimulus("vecA1", 0, v, 8'b000111, 1'b0, 1'b0, none, 8'h0);

    v[0] = 8'b000010; v[1] = 8'b010000; v[2] = 8'b001000; v[3] = 8'b010100; v[4] = 8'b000100;
    applyStimulus("vecA2", 0, v, 8'b000000, 1'b0, 1'b0, none, 8'h0);

    v[0] = 8'b111011; v[1] = 8'b011011; v[2] = 8'b001111; v[3] = 8'b010111; v[4] = 8'b110101;
    applyStimulus("vecA3", 0, v, 8'b011111, 1'b0, 1'b0, none, 8'h0);

    // Abort from a non-zero previous result.
    abortTest("abortA", 0, randVec());

    // Even count: ties on bits 1 and 2 resolve to 0, bit 0 has three ones.
    v = '0;
    v[0] = 8'b000011; v[1] = 8'b000101; v[2] = 8'b000110; v[3] = 8'b000001;
    applyStimulus("tieB", 1, v, 8'b000001, 1'b0, 1'b0, none, 8'h0);

    // en held high and inputs scrambled while busy.
    for (int r = 0; r < 3; r++) begin
      v = randVec();
      applyStimulus($sformatf("scrambleA%0d", r), 0, v, refMajority(v, 5, 6), 1'b1, 1'b0, none, 8'h0);
    end

    // Back-to-back: new start on the edge where out is asserted.
    v  = randVec();
    v2 = randVec();
    applyStimulus("chainA", 0, v, refMajority(v, 5, 6), 1'b0, 1'b1, v2, refMajority(v2, 5, 6));

    // Random sets on the even-count and partial-chunk instances.
    for (int r = 0; r < 4; r++) begin
      v = randVec();
      applyStimulus($sformatf("randB%0d", r), 1, v, refMajority(v, 4, 6), r[0], 1'b0, none, 8'h0);
      v = randVec();
      applyStimulus($sformatf("randC%0d", r), 2, v, refMajority(v, 5, 7), r[0], 1'b0, none, 8'h0);
    end

    v  = randVec();
    v2 = randVec();
    applyStimulus("chainC", 2, v, refMajority(v, 5, 7), 1'b0, 1'b1, v2, refMajority(v2, 5, 7));

    abortTest("abortC", 2, randVec());

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
